// File: rtl/fs4_mixer_arbiter_if.sv
// Bus bundle for the shared fs/4 rotator: per-channel AXIS sample inputs,
// grant enable, phase controls and the single tagged AXIS output.
//
// Handshake: every AXIS link transfers a beat on a rising clk edge where
// valid and ready are both high. A source holds valid and data stable until
// that edge. The rotator's s_ready_o never waits on the granted channel's
// own valid beyond the arbiter search. Downstream may drop m_ready_i at will.
interface fs4_mixer_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2
);
    logic                         enable_i;
    logic [NUM_CH-1:0]            s_valid_i;
    logic [NUM_CH-1:0]            s_ready_o;
    logic [NUM_CH*DATA_WIDTH-1:0] s_I_i;
    logic [NUM_CH*DATA_WIDTH-1:0] s_Q_i;
    logic [NUM_CH-1:0]            s_dir_i;
    logic [NUM_CH-1:0]            phase_clr_i;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic [DATA_WIDTH-1:0]        m_I_o;
    logic [DATA_WIDTH-1:0]        m_Q_o;
    logic [CH_W-1:0]              m_ch_o;

    // Rotator side.
    modport slave (
        input  enable_i, s_valid_i, s_I_i, s_Q_i, s_dir_i, phase_clr_i, m_ready_i,
        output s_ready_o, m_valid_o, m_I_o, m_Q_o, m_ch_o
    );

    // Environment side: sources, controller and downstream sink.
    modport master (
        output enable_i, s_valid_i, s_I_i, s_Q_i, s_dir_i, phase_clr_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_I_o, m_Q_o, m_ch_o
    );
endinterface

// File: rtl/fs4_mixer_arbiter.sv
// Time-shared fs/4 quarter-rate rotator. A round-robin arbiter picks one
// requesting channel per cycle. Its sample is rotated by that channel's own
// 2-bit phase and lands in a registered, channel-tagged output slot.
module fs4_mixer_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2
) (
    input logic                clk_i,
    input logic                reset_i,
    fs4_mixer_arbiter_if.slave bus
);
    logic [1:0]            phase [NUM_CH];
    logic [CH_W-1:0]       last_grant;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_i_q;
    logic [DATA_WIDTH-1:0] m_q_q;
    logic [CH_W-1:0]       m_ch_q;

    logic                  load;
    logic                  found;
    logic                  accept;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       idx_w;
    int                    idx;
    logic [DATA_WIDTH-1:0] sel_i;
    logic [DATA_WIDTH-1:0] sel_q;
    logic [1:0]            sel_p;
    logic                  sel_dir;
    logic [DATA_WIDTH-1:0] rot_i;
    logic [DATA_WIDTH-1:0] rot_q;
    logic [NUM_CH-1:0]     ready;

    // The output slot can take a new sample when it is empty or draining this edge.
    assign load = bus.enable_i && (!m_valid_q || bus.m_ready_i);

    // Round-robin search from last_grant+1 with wrap. Also picks the winner's data, phase and direction.
    always_comb begin
        found   = 1'b0;
        grant   = '0;
        idx     = 0;
        idx_w   = '0;
        sel_i   = '0;
        sel_q   = '0;
        sel_p   = 2'd0;
        sel_dir = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = CH_W'(idx);
            if (!found && bus.s_valid_i[idx_w]) begin
                found   = 1'b1;
                grant   = idx_w;
                sel_i   = bus.s_I_i[idx_w*DATA_WIDTH +: DATA_WIDTH];
                sel_q   = bus.s_Q_i[idx_w*DATA_WIDTH +: DATA_WIDTH];
                sel_p   = phase[idx_w];
                sel_dir = bus.s_dir_i[idx_w];
            end
        end
    end

    // Ready is one-hot on the winner, and is held low during reset or when the slot is blocked.
    always_comb begin
        accept = load && found && !reset_i;
        ready  = '0;
        if (accept) begin
            ready = NUM_CH'(1) << grant;
        end
    end

    // Quarter-rate rotation. Negation wraps at DATA_WIDTH, so the most negative value maps to itself.
    always_comb begin
        rot_i = sel_i;
        rot_q = sel_q;
        case (sel_p)
            2'd0: begin rot_i = sel_i;  rot_q = sel_q;  end
            2'd1: begin rot_i = -sel_q; rot_q = sel_i;  end
            2'd2: begin rot_i = -sel_i; rot_q = -sel_q; end
            default: begin rot_i = sel_q; rot_q = -sel_i; end
        endcase
    end

    // Output slot and grant pointer. Load on accept, clear on drain, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_valid_q  <= 1'b0;
            m_i_q      <= '0;
            m_q_q      <= '0;
            m_ch_q     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (accept) begin
            m_valid_q  <= 1'b1;
            m_i_q      <= rot_i;
            m_q_q      <= rot_q;
            m_ch_q     <= grant;
            last_grant <= grant;
        end else if (bus.m_ready_i) begin
            m_valid_q  <= 1'b0;
        end
    end

    // Per-channel phase. A clear beats the step taken on that channel's own accept.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset_i || bus.phase_clr_i[k]) begin
                phase[k] <= 2'd0;
            end else if (accept && grant == CH_W'(k)) begin
                phase[k] <= sel_dir ? phase[k] + 2'd1 : phase[k] - 2'd1;
            end
        end
    end

    assign bus.s_ready_o = ready;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_I_o     = m_i_q;
    assign bus.m_Q_o     = m_q_q;
    assign bus.m_ch_o    = m_ch_q;
endmodule

// File: tb/tb_fs4_mixer_arbiter.sv
// Bench for fs4_mixer_arbiter. Scenario tasks drive channels and check
// s_ready_o and output-slot status inline. Each accepted sample pushes its
// expected {ch, I, Q} onto exp_q. A negedge monitor pops and compares
// every beat that downstream consumes.
module tb_fs4_mixer_arbiter;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int W  = CW + 2 * DW;

  logic clk = 1'b0;
  logic reset_i;

  fs4_mixer_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .CH_W(CW)) bus ();

  fs4_mixer_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .CH_W(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [1:0] ph [NC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // scoreboard: a beat is consumed on the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    if (!reset_i && bus.m_valid_o && bus.m_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got ch=%0d I=%0d Q=%0d, required no output",
                 bus.m_ch_o, $signed(bus.m_I_o), $signed(bus.m_Q_o));
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.m_ch_o, bus.m_I_o, bus.m_Q_o} !== mon_e) begin
          n_err++;
          $display("FAIL sb_data: got ch=%0d I=%0d Q=%0d, required ch=%0d I=%0d Q=%0d",
                   bus.m_ch_o, $signed(bus.m_I_o), $signed(bus.m_Q_o),
                   mon_e[W-1 -: CW], $signed(mon_e[2*DW-1 -: DW]), $signed(mon_e[DW-1:0]));
        end
      end
    end
  end

  function automatic logic [2*DW-1:0] rot_ref(input logic [DW-1:0] i, input logic [DW-1:0] q,
                                              input logic [1:0] p);
    logic [DW-1:0] ni, nq;
    ni = ~i + 1'b1;
    nq = ~q + 1'b1;
    case (p)
      2'd0:    return {i, q};
      2'd1:    return {nq, i};
      2'd2:    return {ni, nq};
      default: return {q, ni};
    endcase
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int ch, input int i, input int q);
    bus.s_I_i[ch*DW +: DW] = DW'(i);
    bus.s_Q_i[ch*DW +: DW] = DW'(q);
  endtask

  task automatic push_exp(input int ch, input int i, input int q);
    exp_q.push_back({CW'(ch), DW'(i), DW'(q)});
  endtask

  task automatic push_rot(input int ch, input logic [1:0] p);
    exp_q.push_back({CW'(ch), rot_ref(bus.s_I_i[ch*DW +: DW], bus.s_Q_i[ch*DW +: DW], p)});
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    bus.enable_i = 1'b1;
    bus.m_ready_i = 1'b1;
    bus.s_valid_i = '1;
    bus.s_dir_i = '1;
    bus.phase_clr_i = '0;
    bus.s_I_i = '0;
    bus.s_Q_i = '0;
    tick();
    tick();
    n_cmp++;
    if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid_o); end
    n_cmp++;
    if (bus.m_I_o !== '0) begin n_err++; $display("FAIL reset_m_I: got %0d, required 0", bus.m_I_o); end
    n_cmp++;
    if (bus.m_Q_o !== '0) begin n_err++; $display("FAIL reset_m_Q: got %0d, required 0", bus.m_Q_o); end
    n_cmp++;
    if (bus.m_ch_o !== '0) begin n_err++; $display("FAIL reset_m_ch: got %0d, required 0", bus.m_ch_o); end
    n_cmp++;
    if (bus.s_ready_o !== '0) begin n_err++; $display("FAIL reset_s_ready: got %b, required 0000", bus.s_ready_o); end
    bus.s_valid_i = '0;
    reset_i = 1'b0;
    for (int k = 0; k < NC; k++) ph[k] = 2'd0;
  endtask

  task automatic test_single_up;
    int ei [4] = '{10, -3, -10, 3};
    int eq [4] = '{3, 10, -3, -10};
    set_data(0, 10, 3);
    bus.s_dir_i[0] = 1'b1;
    bus.s_valid_i = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (bus.s_ready_o !== 4'b0001) begin n_err++; $display("FAIL up_ready c=%0d: got %b, required 0001", c, bus.s_ready_o); end
      push_exp(0, ei[c], eq[c]);
      tick();
      n_cmp++;
      if (bus.m_valid_o !== 1'b1) begin n_err++; $display("FAIL up_latency c=%0d: got m_valid=%b, required 1", c, bus.m_valid_o); end
    end
    bus.s_valid_i = '0;
  endtask

  task automatic test_dir_down;
    int ei [4] = '{10, 3, -10, -3};
    int eq [4] = '{3, -10, -3, 10};
    set_data(1, 10, 3);
    bus.s_dir_i[1] = 1'b0;
    bus.s_valid_i = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (bus.s_ready_o !== 4'b0010) begin n_err++; $display("FAIL down_ready c=%0d: got %b, required 0010", c, bus.s_ready_o); end
      push_exp(1, ei[c], eq[c]);
      tick();
    end
    bus.s_valid_i = '0;
  endtask

  task automatic test_all_channels;
    logic [NC-1:0] oh;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int k = 0; k < NC; k++) begin
      ph[k] = 2'd0;
      set_data(k, 10 * (k + 1), k + 1);
    end
    bus.s_dir_i = '1;
    bus.s_valid_i = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      oh = NC'(1) << (c % NC);
      n_cmp++;
      if (bus.s_ready_o !== oh) begin n_err++; $display("FAIL rr_ready c=%0d: got %b, required %b", c, bus.s_ready_o, oh); end
      push_rot(c % NC, ph[c % NC]);
      ph[c % NC] = ph[c % NC] + 2'd1;
      tick();
    end
  endtask

  task automatic test_backpressure;
    bus.m_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.s_ready_o !== '0) begin n_err++; $display("FAIL bp_ready c=%0d: got %b, required 0000", c, bus.s_ready_o); end
      n_cmp++;
      if (bus.m_valid_o !== 1'b1 || exp_q.size() != 1 || {bus.m_ch_o, bus.m_I_o, bus.m_Q_o} !== exp_q[0]) begin
        n_err++;
        $display("FAIL bp_hold c=%0d: got v=%b ch=%0d I=%0d Q=%0d, required held ch=1 beat",
                 c, bus.m_valid_o, bus.m_ch_o, $signed(bus.m_I_o), $signed(bus.m_Q_o));
      end
      tick();
    end
    bus.m_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_ready_o !== 4'b0100) begin n_err++; $display("FAIL bp_resume0: got %b, required 0100", bus.s_ready_o); end
    push_rot(2, ph[2]);
    ph[2] = ph[2] + 2'd1;
    tick();
    #1;
    n_cmp++;
    if (bus.s_ready_o !== 4'b1000) begin n_err++; $display("FAIL bp_resume1: got %b, required 1000", bus.s_ready_o); end
    push_rot(3, ph[3]);
    ph[3] = ph[3] + 2'd1;
    tick();
    bus.s_valid_i = '0;
  endtask

  task automatic test_phase_clear;
    set_data(2, 20, 7);
    bus.s_valid_i = 4'b0100;
    bus.phase_clr_i = 4'b0100;
    #1;
    n_cmp++;
    if (bus.s_ready_o !== 4'b0100) begin n_err++; $display("FAIL clr_ready0: got %b, required 0100", bus.s_ready_o); end
    push_exp(2, -20, -7);
    tick();
    bus.phase_clr_i = '0;
    #1;
    n_cmp++;
    if (bus.s_ready_o !== 4'b0100) begin n_err++; $display("FAIL clr_ready1: got %b, required 0100", bus.s_ready_o); end
    push_exp(2, 20, 7);
    ph[2] = 2'd1;
    tick();
  endtask

  task automatic test_neg_wrap;
    set_data(2, -128, 0);
    push_exp(2, 0, -128);
    tick();
    push_exp(2, -128, 0);
    ph[2] = 2'd3;
    tick();
    bus.s_valid_i = '0;
  endtask

  task automatic test_enable_low;
    bus.enable_i = 1'b0;
    set_data(0, 5, -6);
    bus.s_valid_i = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.s_ready_o !== '0) begin n_err++; $display("FAIL en_ready c=%0d: got %b, required 0000", c, bus.s_ready_o); end
      tick();
    end
    n_cmp++;
    if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL en_drain: got m_valid=%b, required 0", bus.m_valid_o); end
    bus.enable_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_ready_o !== 4'b0001) begin n_err++; $display("FAIL en_resume: got %b, required 0001", bus.s_ready_o); end
    push_exp(0, -5, 6);
    tick();
  endtask

  task automatic test_reset_midstream;
    reset_i = 1'b1;
    bus.s_valid_i = 4'b0111;
    #1;
    n_cmp++;
    if (bus.s_ready_o !== '0) begin n_err++; $display("FAIL rst_ready: got %b, required 0000", bus.s_ready_o); end
    exp_q.delete();
    tick();
    n_cmp++;
    if (bus.m_valid_o !== 1'b0 || bus.m_I_o !== '0) begin
      n_err++;
      $display("FAIL rst_discard: got v=%b I=%0d, required v=0 I=0", bus.m_valid_o, bus.m_I_o);
    end
    reset_i = 1'b0;
    set_data(0, 5, -6);
    set_data(1, 11, -4);
    set_data(2, -128, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.s_ready_o !== NC'(1) << c) begin n_err++; $display("FAIL rst_grant c=%0d: got %b, required %b", c, bus.s_ready_o, NC'(1) << c); end
      push_rot(c, 2'd0);
      tick();
    end
    bus.s_valid_i = '0;
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_dir_down();
    test_all_channels();
    test_backpressure();
    test_phase_clear();
    test_neg_wrap();
    test_enable_low();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
